// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry FF, LSB first over WIDTH clocks.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q;
    logic [WIDTH-2:0] psum_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;

    logic             s_d, c_d;
    logic [WIDTH-1:0] psum_d;

    // The full-adder cell; psum_d is the partial sum with this cycle's bit at the MSB.
    assign s_d    = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    assign c_d    = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & c_q) | (b_sr_q[0] & c_q);
    assign psum_d = {s_d, psum_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            psum_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr_q  <= a;
                        b_sr_q  <= b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr_q <= a_sr_q >> 1;
                    b_sr_q <= b_sr_q >> 1;
                    psum_q <= psum_d[WIDTH-1:1];
                    c_q    <= c_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum     <= psum_d;
                        cout    <= c_d;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= DONE;
`ifdef SERIAL_ADDER_OVF_EN
                        // c_q is the carry into the MSB on the last bit.
                        ovf     <= c_q ^ c_d;
`endif
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
